// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses ({rd, sel}), exception codes,
// Status/Cause bit positions and reset values.
package cp0_regfile_pkg;

    // CP0 register addresses as {rd[4:0], sel[2:0]}
    localparam logic [7:0] CP0_ADDR_BADVADDR = 8'h40;  // {8, 0}
    localparam logic [7:0] CP0_ADDR_COUNT    = 8'h48;  // {9, 0}
    localparam logic [7:0] CP0_ADDR_COMPARE  = 8'h58;  // {11,0}
    localparam logic [7:0] CP0_ADDR_STATUS   = 8'h60;  // {12,0}
    localparam logic [7:0] CP0_ADDR_CAUSE    = 8'h68;  // {13,0}
    localparam logic [7:0] CP0_ADDR_EPC      = 8'h70;  // {14,0}

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // Status bit positions
    localparam int STATUS_BEV    = 22;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IE     = 0;

    // Cause bit positions
    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_IPHW_LO = 10;
    localparam int CAUSE_IPSW_LO = 8;
    localparam int CAUSE_EXC_LO  = 2;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    // Address-error exceptions are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Write-back stage <-> CP0 request/response bundle.
// Requests (wb_ex, eret_flush, mtc0_we) are single-cycle strobes with no
// ready: CP0 always accepts and commits them on the next rising edge.
// cp0_rdata is combinational from cp0_addr; the other responses are registered.
interface cp0_regfile_if;
    logic        wb_ex;
    logic        wb_bd;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        eret_flush;
    logic [5:0]  ext_int_in;
    logic [7:0]  cp0_addr;
    logic        mtc0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic        int_pending;

    modport master (
        output wb_ex, wb_bd, wb_excode, wb_pc, wb_badvaddr, eret_flush,
               ext_int_in, cp0_addr, mtc0_we, cp0_wdata,
        input  cp0_rdata, cp0_epc, cp0_status, cp0_cause, int_pending
    );

    modport slave (
        input  wb_ex, wb_bd, wb_excode, wb_pc, wb_badvaddr, eret_flush,
               ext_int_in, cp0_addr, mtc0_we, cp0_wdata,
        output cp0_rdata, cp0_epc, cp0_status, cp0_cause, int_pending
    );
endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: prescaler, 32-bit Count, Compare and the sticky TI flag.
// Only instantiated when CP0_TIMER_INT_EN is defined.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;

    // Next-state: a Count write restarts the prescaler; a Compare write clears TI
    // and overrides a match seen in the same cycle.
    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (count_we) begin
            count_d = wdata;
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr (+ Count/Compare timer).
// Optional feature macro: CP0_TIMER_INT_EN enables the Count/Compare timer
// and its TI interrupt; without it those registers read as 0.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic          clk,
    input  logic          resetn,
    cp0_regfile_if.slave  bus
);
    // Architectural state
    logic [7:0]  status_im_q, status_im_d;
    logic        status_exl_q, status_exl_d;
    logic        status_ie_q, status_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
    logic [5:0]  cause_ip_hw_q, cause_ip_hw_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        int_pending_q, int_pending_d;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        mtc0_en;
    logic [31:0] status_word;
    logic [31:0] cause_word;
    logic [31:0] rdata;

    // An mtc0 only commits when no exception or eret claims the cycle
    assign mtc0_en = bus.mtc0_we & ~bus.wb_ex & ~bus.eret_flush;

`ifdef CP0_TIMER_INT_EN
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0_en && (bus.cp0_addr == CP0_ADDR_COUNT)),
        .compare_we (mtc0_en && (bus.cp0_addr == CP0_ADDR_COMPARE)),
        .wdata      (bus.cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    logic [31:0] unused_count_div;
    assign unused_count_div = 32'(COUNT_DIV);
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    // Next-state: exception beats eret beats mtc0; IP hardware bits sample every cycle
    always_comb begin
        status_im_d   = status_im_q;
        status_exl_d  = status_exl_q;
        status_ie_d   = status_ie_q;
        cause_bd_d    = cause_bd_q;
        cause_exc_d   = cause_exc_q;
        cause_ip_sw_d = cause_ip_sw_q;
        epc_d         = epc_q;
        badvaddr_d    = badvaddr_q;
        cause_ip_hw_d = {bus.ext_int_in[5] | ti, bus.ext_int_in[4:0]};
        int_pending_d = (|({cause_ip_hw_q, cause_ip_sw_q} & status_im_q))
                        & status_ie_q & ~status_exl_q;

        if (bus.wb_ex) begin
            cause_exc_d  = bus.wb_excode;
            status_exl_d = 1'b1;
            // Nested exceptions keep the original return address and BD
            if (!status_exl_q) begin
                epc_d      = bus.wb_bd ? (bus.wb_pc - 32'd4) : bus.wb_pc;
                cause_bd_d = bus.wb_bd;
            end
            if (is_addr_exc(bus.wb_excode)) begin
                badvaddr_d = bus.wb_badvaddr;
            end
        end else if (bus.eret_flush) begin
            status_exl_d = 1'b0;
        end else if (mtc0_en) begin
            case (bus.cp0_addr)
                CP0_ADDR_STATUS: begin
                    status_im_d  = bus.cp0_wdata[STATUS_IM_LO +: 8];
                    status_exl_d = bus.cp0_wdata[STATUS_EXL];
                    status_ie_d  = bus.cp0_wdata[STATUS_IE];
                end
                CP0_ADDR_CAUSE: cause_ip_sw_d = bus.cp0_wdata[CAUSE_IPSW_LO +: 2];
                CP0_ADDR_EPC:   epc_d         = bus.cp0_wdata;
                default: ;
            endcase
        end
    end

    // CP0 state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im_q   <= '0;
            status_exl_q  <= 1'b0;
            status_ie_q   <= 1'b0;
            cause_bd_q    <= 1'b0;
            cause_exc_q   <= '0;
            cause_ip_sw_q <= '0;
            cause_ip_hw_q <= '0;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            int_pending_q <= 1'b0;
        end else begin
            status_im_q   <= status_im_d;
            status_exl_q  <= status_exl_d;
            status_ie_q   <= status_ie_d;
            cause_bd_q    <= cause_bd_d;
            cause_exc_q   <= cause_exc_d;
            cause_ip_sw_q <= cause_ip_sw_d;
            cause_ip_hw_q <= cause_ip_hw_d;
            epc_q         <= epc_d;
            badvaddr_q    <= badvaddr_d;
            int_pending_q <= int_pending_d;
        end
    end

    // Assemble the architectural register views
    always_comb begin
        status_word = STATUS_RESET;
        status_word[STATUS_IM_LO +: 8] = status_im_q;
        status_word[STATUS_EXL]        = status_exl_q;
        status_word[STATUS_IE]         = status_ie_q;

        cause_word = '0;
        cause_word[CAUSE_BD]             = cause_bd_q;
        cause_word[CAUSE_TI]             = ti;
        cause_word[CAUSE_IPHW_LO +: 6]   = cause_ip_hw_q;
        cause_word[CAUSE_IPSW_LO +: 2]   = cause_ip_sw_q;
        cause_word[CAUSE_EXC_LO +: 5]    = cause_exc_q;
    end

    // mfc0 read mux; unimplemented addresses read 0
    always_comb begin
        rdata = '0;
        case (bus.cp0_addr)
            CP0_ADDR_STATUS:   rdata = status_word;
            CP0_ADDR_CAUSE:    rdata = cause_word;
            CP0_ADDR_EPC:      rdata = epc_q;
            CP0_ADDR_BADVADDR: rdata = badvaddr_q;
            CP0_ADDR_COUNT:    rdata = count;
            CP0_ADDR_COMPARE:  rdata = compare;
            default:           rdata = '0;
        endcase
    end

    assign bus.cp0_rdata   = rdata;
    assign bus.cp0_epc     = epc_q;
    assign bus.cp0_status  = status_word;
    assign bus.cp0_cause   = cause_word;
    assign bus.int_pending = int_pending_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// Testbench for cp0_regfile: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural CP0 model.
module tb_cp0_regfile;
    import cp0_regfile_pkg::*;

    localparam int COUNT_DIV = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cp0_regfile_if bus ();

    cp0_regfile #(.COUNT_DIV(COUNT_DIV)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // ---------------- behavioural model ----------------
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_int;
    logic [4:0]  m_excode;
    logic [1:0]  m_ip_sw;
    logic [5:0]  m_ip_hw;
    logic [31:0] m_epc, m_badv, m_cnt_base, m_compare;
    int unsigned m_cyc;   // edges since reset or last Count write

    function automatic logic [31:0] m_count();
`ifdef CP0_TIMER_INT_EN
        return m_cnt_base + 32'(m_cyc / COUNT_DIV);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | {16'h0, m_im, 6'h0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'h0, m_ip_hw, m_ip_sw, 1'b0, m_excode, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            CP0_ADDR_STATUS:   return m_status();
            CP0_ADDR_CAUSE:    return m_cause();
            CP0_ADDR_EPC:      return m_epc;
            CP0_ADDR_BADVADDR: return m_badv;
            CP0_ADDR_COUNT:    return m_count();
            CP0_ADDR_COMPARE:  return m_compare;
            default:           return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_int = 0;
        m_excode = '0; m_ip_sw = '0; m_ip_hw = '0;
        m_epc = '0; m_badv = '0; m_cnt_base = '0; m_compare = '0; m_cyc = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic m_step();
        logic ex, er, wr, n_int, n_ti;
        logic [5:0] n_hw;
        logic [31:0] cnt_now;
        ex = bus.wb_ex;
        er = bus.eret_flush;
        wr = bus.mtc0_we && !ex && !er;
        cnt_now = m_count();
        n_int = (|({m_ip_hw, m_ip_sw} & m_im)) && m_ie && !m_exl;
        n_hw = {bus.ext_int_in[5] | m_ti, bus.ext_int_in[4:0]};
`ifdef CP0_TIMER_INT_EN
        n_ti = (wr && bus.cp0_addr == CP0_ADDR_COMPARE) ? 1'b0 : (m_ti || cnt_now == m_compare);
        if (wr && bus.cp0_addr == CP0_ADDR_COUNT) begin
            m_cnt_base = bus.cp0_wdata;
            m_cyc = 0;
        end else begin
            m_cyc++;
        end
        if (wr && bus.cp0_addr == CP0_ADDR_COMPARE) m_compare = bus.cp0_wdata;
`else
        n_ti = 1'b0;
`endif
        if (ex) begin
            m_excode = bus.wb_excode;
            if (!m_exl) begin
                m_epc = bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
                m_bd  = bus.wb_bd;
            end
            if (bus.wb_excode == EXC_ADEL || bus.wb_excode == EXC_ADES) m_badv = bus.wb_badvaddr;
            m_exl = 1;
        end else if (er) begin
            m_exl = 0;
        end else if (wr) begin
            if (bus.cp0_addr == CP0_ADDR_STATUS) begin
                m_im  = bus.cp0_wdata[15:8];
                m_exl = bus.cp0_wdata[1];
                m_ie  = bus.cp0_wdata[0];
            end
            if (bus.cp0_addr == CP0_ADDR_CAUSE) m_ip_sw = bus.cp0_wdata[9:8];
            if (bus.cp0_addr == CP0_ADDR_EPC)   m_epc = bus.cp0_wdata;
        end
        m_ip_hw = n_hw;
        m_ti    = n_ti;
        m_int   = n_int;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e;
        exp_q.push_back(m_read(bus.cp0_addr));
        e = exp_q.pop_front();
        chk($sformatf("model rdata @%02h", bus.cp0_addr), bus.cp0_rdata, e);
        chk("model epc", bus.cp0_epc, m_epc);
        chk("model status", bus.cp0_status, m_status());
        chk("model cause", bus.cp0_cause, m_cause());
        chk("model int_pending", 32'(bus.int_pending), 32'(m_int));
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic ex, input logic bd, input logic [4:0] code,
                         input logic [31:0] pc, input logic [31:0] badv, input logic eret,
                         input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        bus.wb_ex = ex; bus.wb_bd = bd; bus.wb_excode = code; bus.wb_pc = pc;
        bus.wb_badvaddr = badv; bus.eret_flush = eret; bus.mtc0_we = we;
        bus.cp0_addr = addr; bus.cp0_wdata = wdata;
    endtask

    task automatic idle(input logic [7:0] addr);
        drive(0, 0, 5'h0, 32'h0, 32'h0, 0, 0, addr, 32'h0);
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] wdata);
        drive(0, 0, 5'h0, 32'h0, 32'h0, 0, 1, addr, wdata);
    endtask

    // One clock edge: model advances, DUT is sampled 1 time unit later
    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset between edges and check it takes effect without a clock
    task automatic pulse_reset();
        idle(CP0_ADDR_STATUS);
        bus.ext_int_in = '0;
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        m_reset();
        chk("reset epc", bus.cp0_epc, 32'h0);
        chk("reset status", bus.cp0_status, 32'h0040_0000);
        chk("reset cause", bus.cp0_cause, 32'h0);
        chk("reset int_pending", 32'(bus.int_pending), 32'h0);
        chk("reset rdata status", bus.cp0_rdata, 32'h0040_0000);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ex;
        logic        bd;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] badv;
        logic        eret;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] e_epc;
        logic [31:0] e_status;
        logic [31:0] e_cause;
        logic [31:0] e_rdata;
        logic        e_int;
    } vec_t;

    vec_t vq[$];

    initial begin
        logic [7:0] addrs[8];
        logic [4:0] codes[7];
        vec_t v;

        resetn = 1'b0;
        bus.ext_int_in = '0;
        idle(CP0_ADDR_STATUS);
        m_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Park Compare far from Count so TI stays quiet during the table
        tick();
        mtc0(CP0_ADDR_COMPARE, 32'hFFFF_FFFF);
        tick();
        idle(CP0_ADDR_STATUS);
        tick();
        tick();
        chk("quiet cause", bus.cp0_cause, 32'h0);

        //            ex bd code      pc            badv          er we addr               wdata         epc           status        cause         rdata         int
        vq.push_back('{1, 0, EXC_SYS,  32'hBFC0_0100, 32'h0,        0, 0, CP0_ADDR_EPC,      32'h0,        32'hBFC0_0100, 32'h0040_0002, 32'h0000_0020, 32'hBFC0_0100, 0});
        vq.push_back('{1, 1, EXC_SYS,  32'h0000_0200, 32'h0,        0, 0, CP0_ADDR_CAUSE,    32'h0,        32'hBFC0_0100, 32'h0040_0002, 32'h0000_0020, 32'h0000_0020, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        1, 0, CP0_ADDR_STATUS,   32'h0,        32'hBFC0_0100, 32'h0040_0000, 32'h0000_0020, 32'h0040_0000, 0});
        vq.push_back('{1, 0, EXC_ADEL, 32'h0000_0300, 32'h0000_1001, 0, 0, CP0_ADDR_BADVADDR, 32'h0,        32'h0000_0300, 32'h0040_0002, 32'h0000_0010, 32'h0000_1001, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        1, 0, CP0_ADDR_BADVADDR, 32'h0,        32'h0000_0300, 32'h0040_0000, 32'h0000_0010, 32'h0000_1001, 0});
        vq.push_back('{1, 1, EXC_SYS,  32'h0000_0400, 32'h0000_FFFF, 0, 0, CP0_ADDR_BADVADDR, 32'h0,        32'h0000_03FC, 32'h0040_0002, 32'h8000_0020, 32'h0000_1001, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        1, 0, CP0_ADDR_CAUSE,    32'h0,        32'h0000_03FC, 32'h0040_0000, 32'h8000_0020, 32'h8000_0020, 0});
        vq.push_back('{1, 0, EXC_OV,   32'h0000_0500, 32'h0,        0, 1, CP0_ADDR_EPC,      32'hDEAD_BEEF, 32'h0000_0500, 32'h0040_0002, 32'h0000_0030, 32'h0000_0500, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        1, 1, CP0_ADDR_STATUS,   32'h0000_0003, 32'h0000_0500, 32'h0040_0000, 32'h0000_0030, 32'h0040_0000, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        0, 1, CP0_ADDR_EPC,      32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0040_0000, 32'h0000_0030, 32'hDEAD_BEEF, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        0, 1, CP0_ADDR_STATUS,   32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0040_FF03, 32'h0000_0030, 32'h0040_FF03, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        0, 1, CP0_ADDR_STATUS,   32'h0000_0101, 32'hDEAD_BEEF, 32'h0040_0101, 32'h0000_0030, 32'h0040_0101, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        0, 1, CP0_ADDR_CAUSE,    32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0040_0101, 32'h0000_0330, 32'h0000_0330, 0});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        0, 0, CP0_ADDR_CAUSE,    32'h0,        32'hDEAD_BEEF, 32'h0040_0101, 32'h0000_0330, 32'h0000_0330, 1});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        0, 1, CP0_ADDR_STATUS,   32'h0000_0103, 32'hDEAD_BEEF, 32'h0040_0103, 32'h0000_0330, 32'h0040_0103, 1});
        vq.push_back('{0, 0, 5'h0,     32'h0,         32'h0,        0, 0, 8'h08,             32'h0,        32'hDEAD_BEEF, 32'h0040_0103, 32'h0000_0330, 32'h0000_0000, 0});
        vq.push_back('{1, 0, EXC_ADES, 32'h0000_0600, 32'h0000_2002, 0, 0, CP0_ADDR_BADVADDR, 32'h0,        32'hDEAD_BEEF, 32'h0040_0103, 32'h0000_0314, 32'h0000_2002, 0});

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.ex, v.bd, v.code, v.pc, v.badv, v.eret, v.we, v.addr, v.wdata);
            tick();
            chk($sformatf("row%0d epc", i), bus.cp0_epc, v.e_epc);
            chk($sformatf("row%0d status", i), bus.cp0_status, v.e_status);
            chk($sformatf("row%0d cause", i), bus.cp0_cause, v.e_cause);
            chk($sformatf("row%0d rdata", i), bus.cp0_rdata, v.e_rdata);
            chk($sformatf("row%0d int_pending", i), 32'(bus.int_pending), 32'(v.e_int));
        end

        // Mid-cycle reset from a busy state
        pulse_reset();

        // ext_int_in: one cycle to Cause.IP, two to int_pending
        mtc0(CP0_ADDR_COMPARE, 32'hFFFF_FFFF);
        tick();
        mtc0(CP0_ADDR_STATUS, 32'h0000_0401);
        tick();
        idle(CP0_ADDR_CAUSE);
        bus.ext_int_in = 6'b000001;
        tick();
        chk("ext cause ip2", bus.cp0_cause, 32'h0000_0400);
        chk("ext int 1 cycle", 32'(bus.int_pending), 32'h0);
        tick();
        chk("ext int 2 cycles", 32'(bus.int_pending), 32'h1);
        bus.ext_int_in = '0;

        // Timer
        pulse_reset();
`ifdef CP0_TIMER_INT_EN
        mtc0(CP0_ADDR_COUNT, 32'd5);
        tick();
        chk("timer count load", bus.cp0_rdata, 32'd5);
        mtc0(CP0_ADDR_COMPARE, 32'd7);
        tick();
        idle(CP0_ADDR_COUNT);
        repeat (3) tick();
        chk("timer count 7", bus.cp0_rdata, 32'd7);
        chk("timer ti before", 32'(bus.cp0_cause[30]), 32'h0);
        tick();
        chk("timer ti set", 32'(bus.cp0_cause[30]), 32'h1);
        mtc0(CP0_ADDR_STATUS, 32'h0000_8001);
        tick();
        idle(CP0_ADDR_COUNT);
        repeat (2) tick();
        chk("timer int_pending", 32'(bus.int_pending), 32'h1);
        mtc0(CP0_ADDR_COMPARE, 32'h20);
        tick();
        chk("timer ti clear", 32'(bus.cp0_cause[30]), 32'h0);
        idle(CP0_ADDR_COUNT);
        repeat (2) tick();
        chk("timer int clear", 32'(bus.int_pending), 32'h0);
`else
        mtc0(CP0_ADDR_COUNT, 32'd5);
        tick();
        chk("no timer count", bus.cp0_rdata, 32'h0);
        mtc0(CP0_ADDR_COMPARE, 32'd7);
        tick();
        chk("no timer compare", bus.cp0_rdata, 32'h0);
        idle(CP0_ADDR_COUNT);
        repeat (3) tick();
        chk("no timer count idle", bus.cp0_rdata, 32'h0);
`endif

        // Software interrupt masked by EXL
        pulse_reset();
        mtc0(CP0_ADDR_STATUS, 32'h0000_0101);
        tick();
        mtc0(CP0_ADDR_CAUSE, 32'h0000_0100);
        tick();
        idle(CP0_ADDR_CAUSE);
        tick();
        chk("sw int pending", 32'(bus.int_pending), 32'h1);
        mtc0(CP0_ADDR_STATUS, 32'h0000_0103);
        tick();
        idle(CP0_ADDR_CAUSE);
        tick();
        chk("sw int exl masked", 32'(bus.int_pending), 32'h0);

        // Randomized traffic against the model
        addrs = '{CP0_ADDR_STATUS, CP0_ADDR_CAUSE, CP0_ADDR_EPC, CP0_ADDR_BADVADDR,
                  CP0_ADDR_COUNT, CP0_ADDR_COMPARE, 8'h00, 8'h61};
        codes = '{EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
        for (int n = 0; n < 3000; n++) begin
            logic [7:0]  a;
            logic [31:0] wd;
            if ($urandom_range(0, 399) == 0) pulse_reset();
            a  = addrs[$urandom_range(0, 7)];
            wd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  codes[$urandom_range(0, 6)], $urandom, $urandom,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, a, wd);
            if ($urandom_range(0, 3) == 0) bus.ext_int_in = 6'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
